// File: rtl/router_pkt_tx.sv
// Router packet source: buffers a whole payload, then sends header, payload and parity.
// Optional ROUTER_TX_PARITY_INJECT_EN adds corrupt_parity to invert the sent parity byte.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
`ifdef ROUTER_TX_PARITY_INJECT_EN
    input  logic       corrupt_parity,
`endif
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       err_addr
);

    // state   | meaning
    // IDLE    | waiting for a command
    // LOAD    | buffering payload, accumulating parity
    // DROP    | discarding payload of an illegal-address command
    // HEADER  | presenting header byte
    // PAYLOAD | presenting buffered payload bytes
    // PARITY  | presenting parity byte with pkt_valid low
    // GAP     | enforced idle time before next header
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DROP,
        S_HEADER,
        S_PAYLOAD,
        S_PARITY,
        S_GAP
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_addr;
    logic [5:0] r_len;
    logic [5:0] r_wr;
    logic [5:0] r_rd;
    logic [7:0] r_parity;
    logic [3:0] r_gap;
    logic       r_tx_done;
    logic       r_err_addr;
    logic [7:0] r_buf [64];
    logic [7:0] w_parity_out;
    logic [7:0] w_data;
    logic       w_cmd_acc;
    logic       w_last_wr;
    logic       w_last_rd;

    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_last_wr = (r_wr == r_len - 6'd1);
    assign w_last_rd = (r_rd == r_len - 6'd1);

`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic r_corrupt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_corrupt <= 1'b0;
        end else if (r_state == S_IDLE && w_cmd_acc) begin
            r_corrupt <= corrupt_parity;
        end
    end

    assign w_parity_out = r_parity ^ {8{r_corrupt}};
`else
    assign w_parity_out = r_parity;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_addr     <= 2'd0;
            r_len      <= 6'd0;
            r_wr       <= 6'd0;
            r_rd       <= 6'd0;
            r_parity   <= 8'd0;
            r_gap      <= 4'd0;
            r_tx_done  <= 1'b0;
            r_err_addr <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tx_done  <= 1'b0;
            r_err_addr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc) begin
                        r_addr     <= cmd_addr;
                        r_len      <= cmd_len;
                        r_parity   <= {cmd_len, cmd_addr};
                        r_wr       <= 6'd0;
                        r_rd       <= 6'd0;
                        r_err_addr <= (cmd_addr == 2'd3);
                    end
                end
                S_LOAD: begin
                    if (pl_valid) begin
                        r_wr     <= r_wr + 6'd1;
                        r_parity <= r_parity ^ pl_data;
                    end
                end
                S_DROP: begin
                    if (pl_valid) begin
                        r_wr <= r_wr + 6'd1;
                    end
                end
                S_PAYLOAD: begin
                    if (!busy) begin
                        r_rd <= r_rd + 6'd1;
                    end
                end
                S_PARITY: begin
                    if (!busy) begin
                        r_tx_done <= 1'b1;
                        r_gap     <= 4'(GAP_CYCLES - 1);
                    end
                end
                S_GAP: begin
                    if (r_gap != 4'd0) begin
                        r_gap <= r_gap - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload RAM has no reset; pointers restart at every command.
    always_ff @(posedge clock) begin
        if (r_state == S_LOAD && pl_valid) begin
            r_buf[r_wr] <= pl_data;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    if (cmd_addr == 2'd3) begin
                        w_next_state = (cmd_len != 6'd0) ? S_DROP : S_IDLE;
                    end else begin
                        w_next_state = (cmd_len != 6'd0) ? S_LOAD : S_HEADER;
                    end
                end
            end
            S_LOAD: begin
                if (pl_valid && w_last_wr) begin
                    w_next_state = S_HEADER;
                end
            end
            S_DROP: begin
                if (pl_valid && w_last_wr) begin
                    w_next_state = S_IDLE;
                end
            end
            S_HEADER: begin
                if (!busy) begin
                    w_next_state = (r_len != 6'd0) ? S_PAYLOAD : S_PARITY;
                end
            end
            S_PAYLOAD: begin
                if (!busy && w_last_rd) begin
                    w_next_state = S_PARITY;
                end
            end
            S_PARITY: begin
                if (!busy) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == 4'd0) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_data = 8'd0;
        case (r_state)
            S_HEADER:  w_data = {r_len, r_addr};
            S_PAYLOAD: w_data = r_buf[r_rd];
            S_PARITY:  w_data = w_parity_out;
            default:   w_data = 8'd0;
        endcase
    end

    // Reset gating keeps every output quiet for the whole reset assertion.
    assign cmd_ready = !reset && (r_state == S_IDLE);
    assign pl_ready  = !reset && (r_state == S_LOAD || r_state == S_DROP);
    assign pkt_valid = !reset && (r_state == S_HEADER || r_state == S_PAYLOAD);
    assign data_out  = reset ? 8'd0 : w_data;
    assign tx_done   = !reset && r_tx_done;
    assign err_addr  = !reset && r_err_addr;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx (GAP_CYCLES = 2).
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_done;
    logic       err_addr;
`ifdef ROUTER_TX_PARITY_INJECT_EN
    logic       corrupt_parity;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    router_pkt_tx #(.GAP_CYCLES(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
`ifdef ROUTER_TX_PARITY_INJECT_EN
        .corrupt_parity (corrupt_parity),
`endif
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .tx_done   (tx_done),
        .err_addr  (err_addr)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
        int k = 0;
        while (!cmd_ready && k < 300) begin
            tick();
            k++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL send_cmd_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit gaps);
        int k = 0;
        if (gaps && $urandom_range(0, 2) == 0) begin
            pl_valid = 1'b0;
            tick();
        end
        pl_valid = 1'b1;
        pl_data  = b;
        while (!pl_ready && k < 50) begin
            tick();
            k++;
        end
        if (!pl_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: pl_ready=%0b required 1", pl_ready);
        end
        tick();
        pl_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!cmd_ready && k < 300) begin
            tick();
            k++;
        end
        n_checks++;
        if (!cmd_ready) begin
            n_fail++;
            $display("FAIL idle_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks += 6;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready: got %0b want 0", cmd_ready); end
        if (pl_ready  !== 1'b0) begin n_fail++; $display("FAIL rst_pl_ready: got %0b want 0", pl_ready); end
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_valid: got %0b want 0", pkt_valid); end
        if (data_out  !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h want 00", data_out); end
        if (tx_done   !== 1'b0) begin n_fail++; $display("FAIL rst_tx_done: got %0b want 0", tx_done); end
        if (err_addr  !== 1'b0) begin n_fail++; $display("FAIL rst_err_addr: got %0b want 0", err_addr); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %0b want 1", cmd_ready); end
        tick();
    endtask

    // Shared stream shape for addr=1 len=3 payload 11/22/33; parity byte passed in.
    task automatic run_basic(input logic [7:0] exp_par, input string tag);
        logic [7:0] ed [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        logic       ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ed[4] = exp_par;
        send_cmd(2'd1, 6'd3);
        n_checks += 2;
        if (pl_ready !== 1'b1) begin n_fail++; $display("FAIL %s_load_ready: got %0b want 1", tag, pl_ready); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s_cmd_ready_busy: got %0b want 0", tag, cmd_ready); end
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                n_checks += 2;
                if (pkt_valid !== ev[c]) begin n_fail++; $display("FAIL %s_valid c%0d: got %0b want %0b", tag, c, pkt_valid, ev[c]); end
                if (data_out !== ed[c]) begin n_fail++; $display("FAIL %s_data c%0d: got %h want %h", tag, c, data_out, ed[c]); end
            end
            if (c < 7) begin
                n_checks++;
                if (tx_done !== (c == 5)) begin n_fail++; $display("FAIL %s_tx_done c%0d: got %0b want %0b", tag, c, tx_done, c == 5); end
            end
            if (c == 5 || c == 6) begin
                n_checks += 2;
                if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL %s_gap_valid c%0d: got %0b want 0", tag, c, pkt_valid); end
                if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL %s_gap_ready c%0d: got %0b want 0", tag, c, cmd_ready); end
            end
            if (c == 7) begin
                n_checks++;
                if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_idle_after_gap: got %0b want 1", tag, cmd_ready); end
            end
            if (c < 7) tick();
        end
    endtask

    task automatic test_basic();
        run_basic(8'h0D, "basic");
    endtask

    task automatic test_zero_len();
        send_cmd(2'd2, 6'd0);
        n_checks += 3;
        if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL zl_hdr_valid: got %0b want 1", pkt_valid); end
        if (data_out !== 8'h02) begin n_fail++; $display("FAIL zl_hdr_data: got %h want 02", data_out); end
        if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL zl_pl_ready0: got %0b want 0", pl_ready); end
        tick();
        n_checks += 3;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL zl_par_valid: got %0b want 0", pkt_valid); end
        if (data_out !== 8'h02) begin n_fail++; $display("FAIL zl_par_data: got %h want 02", data_out); end
        if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL zl_pl_ready1: got %0b want 0", pl_ready); end
        tick();
        n_checks++;
        if (tx_done !== 1'b1) begin n_fail++; $display("FAIL zl_tx_done: got %0b want 1", tx_done); end
        tick();
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL zl_idle: got %0b want 1", cmd_ready); end
    endtask

    task automatic test_busy_stall();
        logic [7:0] ed [7] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'hA5, 8'h5A, 8'hF7};
        logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        send_cmd(2'd0, 6'd2);
        push_byte(8'hA5, 1'b0);
        push_byte(8'h5A, 1'b0);
        for (int c = 0; c < 7; c++) begin
            busy = (c < 3);
            n_checks += 2;
            if (pkt_valid !== ev[c]) begin n_fail++; $display("FAIL stall_valid c%0d: got %0b want %0b", c, pkt_valid, ev[c]); end
            if (data_out !== ed[c]) begin n_fail++; $display("FAIL stall_data c%0d: got %h want %h", c, data_out, ed[c]); end
            if (c < 6) tick();
        end
        busy = 1'b1;
        tick();
        n_checks += 3;
        if (data_out !== 8'hF7) begin n_fail++; $display("FAIL stall_par_hold: got %h want f7", data_out); end
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL stall_par_valid: got %0b want 0", pkt_valid); end
        if (tx_done !== 1'b0) begin n_fail++; $display("FAIL stall_early_done: got %0b want 0", tx_done); end
        busy = 1'b0;
        tick();
        n_checks++;
        if (tx_done !== 1'b1) begin n_fail++; $display("FAIL stall_tx_done: got %0b want 1", tx_done); end
        wait_idle();
    endtask

    task automatic test_illegal_addr();
        send_cmd(2'd3, 6'd4);
        n_checks += 3;
        if (err_addr !== 1'b1) begin n_fail++; $display("FAIL ill_err_addr: got %0b want 1", err_addr); end
        if (pl_ready !== 1'b1) begin n_fail++; $display("FAIL ill_pl_ready: got %0b want 1", pl_ready); end
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ill_valid0: got %0b want 0", pkt_valid); end
        for (int i = 0; i < 4; i++) begin
            push_byte(8'(8'h40 + i), 1'b0);
            n_checks++;
            if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL ill_valid b%0d: got %0b want 0", i, pkt_valid); end
        end
        n_checks += 3;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ill_back_idle: got %0b want 1", cmd_ready); end
        if (err_addr !== 1'b0) begin n_fail++; $display("FAIL ill_err_once: got %0b want 0", err_addr); end
        if (pl_ready !== 1'b0) begin n_fail++; $display("FAIL ill_drop_done: got %0b want 0", pl_ready); end
        send_cmd(2'd3, 6'd0);
        n_checks += 2;
        if (err_addr !== 1'b1) begin n_fail++; $display("FAIL ill0_err_addr: got %0b want 1", err_addr); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ill0_stay_idle: got %0b want 1", cmd_ready); end
        send_cmd(2'd1, 6'd0);
        n_checks += 2;
        if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL ill_next_valid: got %0b want 1", pkt_valid); end
        if (data_out !== 8'h01) begin n_fail++; $display("FAIL ill_next_hdr: got %h want 01", data_out); end
        wait_idle();
    endtask

    task automatic test_max_len();
        send_cmd(2'd0, 6'd63);
        for (int i = 0; i < 63; i++) push_byte(8'(i), 1'b1);
        n_checks += 2;
        if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL max_hdr_valid: got %0b want 1", pkt_valid); end
        if (data_out !== 8'hFC) begin n_fail++; $display("FAIL max_hdr: got %h want fc", data_out); end
        for (int i = 0; i < 63; i++) begin
            tick();
            n_checks += 2;
            if (pkt_valid !== 1'b1) begin n_fail++; $display("FAIL max_pl_valid b%0d: got %0b want 1", i, pkt_valid); end
            if (data_out !== 8'(i)) begin n_fail++; $display("FAIL max_pl_data b%0d: got %h want %h", i, data_out, 8'(i)); end
        end
        tick();
        n_checks += 2;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL max_par_valid: got %0b want 0", pkt_valid); end
        if (data_out !== 8'hC3) begin n_fail++; $display("FAIL max_parity: got %h want c3", data_out); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        send_cmd(2'd1, 6'd3);
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b0);
        push_byte(8'h33, 1'b0);
        tick();
        n_checks++;
        if (data_out !== 8'h11) begin n_fail++; $display("FAIL rm_in_payload: got %h want 11", data_out); end
        reset = 1'b1;
        tick();
        n_checks += 2;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0b want 0", pkt_valid); end
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h want 00", data_out); end
        reset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_after: got %0b want 1", cmd_ready); end
        tick();
        n_checks += 2;
        if (pkt_valid !== 1'b0) begin n_fail++; $display("FAIL rm_stay_idle: got %0b want 0", pkt_valid); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_hold: got %0b want 1", cmd_ready); end
        run_basic(8'h0D, "post_rst");
    endtask

`ifdef ROUTER_TX_PARITY_INJECT_EN
    task automatic test_inject();
        corrupt_parity = 1'b1;
        run_basic(8'hF2, "inject");
        corrupt_parity = 1'b0;
        run_basic(8'h0D, "inject_off");
    endtask
`endif

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 2'd0;
        cmd_len   = 6'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'd0;
        busy      = 1'b0;
`ifdef ROUTER_TX_PARITY_INJECT_EN
        corrupt_parity = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero_len();
        test_busy_stall();
        test_illegal_addr();
        test_max_len();
        test_reset_mid();
`ifdef ROUTER_TX_PARITY_INJECT_EN
        test_inject();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
